// File: rtl/seq_left_rotater_pkg.sv
// Shared ALU definitions for the iterative left rotater: state encodings and default widths.
package seq_left_rotater_pkg;

    localparam int N_DEF = 8;
    localparam int S_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/seq_left_rotater_if.sv
// Request/result bundle between an ALU sequencer (master) and the iterative left rotater (slave).
interface seq_left_rotater_if #(
    parameter int N = seq_left_rotater_pkg::N_DEF,
    parameter int S = seq_left_rotater_pkg::S_DEF
);
    logic         start;
    logic [N-1:0] in_a;
    logic [S-1:0] shift;
    logic [N-1:0] out;
    logic         cout;
    logic         busy;
    logic         done;

    modport master (
        output start, in_a, shift,
        input  out, cout, busy, done
    );

    modport slave (
        input  start, in_a, shift,
        output out, cout, busy, done
    );
endinterface

// File: rtl/seq_left_rotater_rotl1_step.sv
// Combinational rotate-left-by-one; mirrors the single step of the ALU right rotater.
// Latency: 0 cycles. Backpressure: none (pure combinational).
// msb_o is the bit leaving the MSB, which becomes the carry-out of the step.
module seq_left_rotater_rotl1_step #(
    parameter int N = seq_left_rotater_pkg::N_DEF
) (
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o,
    output logic         msb_o
);
    assign q_o   = {d_i[N-2:0], d_i[N-1]};
    assign msb_o = d_i[N-1];
endmodule

// File: rtl/seq_left_rotater.sv
// Multi-cycle N-bit left rotater: one rotate position per clock, result and carry-out with a done pulse.
// Latency: start accepted at edge k -> done high after edge k+shift+1 (throughput shift+3 per op).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, never queued.
module seq_left_rotater
    import seq_left_rotater_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int S = S_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_left_rotater_if.slave    bus
);

    state_e       state_q, state_d;
    logic [N-1:0] acc_q,   acc_d;
    logic [S-1:0] cnt_q,   cnt_d;
    logic         cout_q,  cout_d;

    logic [N-1:0] acc_rot;
    logic         acc_msb;

    seq_left_rotater_rotl1_step #(.N(N)) u_step (
        .d_i   (acc_q),
        .q_o   (acc_rot),
        .msb_o (acc_msb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
        end
    end

    // Counts >= N are walked literally, so the result is naturally modulo N.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.in_a;
                    cnt_d   = bus.shift;
                    cout_d  = 1'b0;
                    state_d = ROTATE;
                end
            end
            ROTATE: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    acc_d  = acc_rot;
                    cout_d = acc_msb;
                    cnt_d  = cnt_q - S'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.out  = acc_q;
    assign bus.cout = cout_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_seq_left_rotater.sv
// Directed and exhaustive self-check of seq_left_rotater (N=8, S=4).
module tb_seq_left_rotater;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   done_runs;
    logic done_prev;

    seq_left_rotater_if #(.N(8), .S(4)) bus ();

    seq_left_rotater #(.N(8), .S(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tracks any done pulse that lasts longer than one cycle.
    always @(negedge clk) begin
        if (bus.done && done_prev) done_runs++;
        done_prev <= bus.done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_rotl(input logic [7:0] a, input int sh);
        logic [15:0] w;
        w = {a, a} << (sh % 8);
        return w[15:8];
    endfunction

    function automatic logic ref_cout(input logic [7:0] a, input int sh);
        if (sh == 0) return 1'b0;
        return a[(8 - (sh % 8)) % 8];
    endfunction

    // Issues one request and returns the number of steps from acceptance to done (-1 on timeout).
    task automatic run_op(input logic [7:0] a, input logic [3:0] s, output int lat);
        bus.start = 1'b1;
        bus.in_a  = a;
        bus.shift = s;
        step();
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;
    int seen;

    initial begin
        tests = 0; fails = 0; done_runs = 0; done_prev = 1'b0;
        bus.start = 1'b0; bus.in_a = '0; bus.shift = '0;
        reset = 1'b1;
        #1;
        chk("rst_out",  bus.out,  8'h00);
        chk("rst_cout", bus.cout, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        step(); step();
        reset = 1'b0;
        step();

        // Single step
        run_op(8'b11110000, 4'd1, lat);
        chk("s1_lat",  lat,      2);
        chk("s1_out",  bus.out,  8'b11100001);
        chk("s1_cout", bus.cout, 1'b1);
        step();
        chk("s1_idle", bus.busy, 1'b0);
        chk("s1_hold", bus.out,  8'b11100001);

        // Multi step
        run_op(8'b01111000, 4'd3, lat);
        chk("s3_lat",  lat,      4);
        chk("s3_out",  bus.out,  8'b11000011);
        chk("s3_cout", bus.cout, 1'b1);
        step();

        // Zero count
        run_op(8'b10100101, 4'd0, lat);
        chk("s0_lat",  lat,      1);
        chk("s0_out",  bus.out,  8'b10100101);
        chk("s0_cout", bus.cout, 1'b0);
        step();

        // Over-range counts
        run_op(8'b00000001, 4'd9, lat);
        chk("s9_lat",  lat,      10);
        chk("s9_out",  bus.out,  8'b00000010);
        chk("s9_cout", bus.cout, 1'b0);
        step();
        run_op(8'b00000001, 4'd8, lat);
        chk("s8_lat",  lat,      9);
        chk("s8_out",  bus.out,  8'b00000001);
        chk("s8_cout", bus.cout, 1'b1);
        step();

        // start during ROTATE and DONE is ignored
        bus.start = 1'b1; bus.in_a = 8'hF0; bus.shift = 4'd3;
        step();
        bus.in_a = 8'h0F; bus.shift = 4'd0;
        step();
        bus.start = 1'b0;
        lat = -1;
        for (int i = 2; i <= 40; i++) begin
            step();
            if (bus.done) begin lat = i; break; end
        end
        chk("ign_lat",  lat,      4);
        chk("ign_out",  bus.out,  8'h87);
        chk("ign_cout", bus.cout, 1'b1);
        bus.start = 1'b1; bus.in_a = 8'h3C; bus.shift = 4'd1;
        step();
        bus.start = 1'b0;
        step();
        chk("ign_busy", bus.busy, 1'b0);
        chk("ign_hold", bus.out,  8'h87);

        // start held high: next op accepted on the first IDLE edge
        bus.start = 1'b1; bus.in_a = 8'h01; bus.shift = 4'd1;
        step();
        bus.in_a = 8'hC1; bus.shift = 4'd2;
        step(); step();
        chk("bb1_done", bus.done, 1'b1);
        chk("bb1_out",  bus.out,  8'h02);
        chk("bb1_cout", bus.cout, 1'b0);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 2) bus.start = 1'b0;
            if (bus.done) begin lat = i; break; end
        end
        chk("bb_gap",   lat,      5);
        chk("bb2_out",  bus.out,  8'h07);
        chk("bb2_cout", bus.cout, 1'b1);
        step();

        // Reset mid-ROTATE aborts with no done
        bus.start = 1'b1; bus.in_a = 8'hF0; bus.shift = 4'd5;
        step();
        bus.start = 1'b0;
        step(); step();
        chk("pre_rst_busy", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out",  bus.out,  8'h00);
        chk("mid_rst_cout", bus.cout, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_done", bus.done, 1'b0);
        step();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done) seen++;
        end
        chk("abort_no_done", seen, 0);

        // Exhaustive formula check
        for (int a = 0; a < 256; a++) begin
            for (int s = 0; s < 16; s++) begin
                run_op(8'(a), 4'(s), lat);
                chk($sformatf("ex_lat a=%0h s=%0d", a, s), lat, s + 1);
                chk($sformatf("ex_out a=%0h s=%0d", a, s), bus.out, ref_rotl(8'(a), s));
                chk($sformatf("ex_cout a=%0h s=%0d", a, s), bus.cout, ref_cout(8'(a), s));
                step();
            end
        end

        chk("done_single_cycle", done_runs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_left_rotater.md
Name: seq_left_rotater

Overview:
Multi-cycle N-bit left rotater. It is the iterative, opposite-direction companion to the combinational right rotater in the ALU.
It accepts an operand and a rotate count on a start strobe, then rotates one position per clock. When finished it presents the result and carry-out with a one-cycle done pulse.
It lives in the ALU and serves multi-cycle shift/rotate instructions where single-cycle barrel logic is too costly.

Parameters:
N, 8, operand/result width in bits (N >= 2)
S, 4, width of the shift-count input; counts up to 2^S-1 are legal and may exceed N

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE
in_a  input  N  operand, captured on the accepted start edge
shift  input  S  rotate count, captured on the accepted start edge
out  output  N  rotated result; valid while done=1 and held until the next accepted start
cout  output  1  last bit rotated out of the MSB; 0 when shift=0
busy  output  1  high in ROTATE and DONE
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high. While reset is high, state=IDLE, out=0, cout=0, busy=0, done=0, internal count=0.
- States: IDLE, ROTATE, DONE.
- IDLE: busy=0, done=0.
  - On a clk edge with start=1: acc<=in_a, count<=shift, cout<=0, next state ROTATE.
  - With start=0: stay in IDLE; out and cout hold.
- ROTATE: busy=1.
  - If count==0: next state DONE; acc and cout unchanged.
  - Otherwise: acc<={acc[N-2:0],acc[N-1]}, cout<=acc[N-1], count<=count-1, stay in ROTATE.
- DONE: busy=1, done=1 for exactly one cycle, next state IDLE unconditionally.
- out is driven from acc.
- Latency: start accepted at edge k gives done=1 in the cycle after edge k+shift+1. shift=0 therefore takes 1 cycle to DONE.
- Results:
  - out = in_a rotated left by (shift mod N).
  - cout = in_a[(N - (shift mod N)) mod N] for shift>=1, and 0 for shift=0.
  - For shift>=1, cout == out[0].
- Counts >= N are performed literally, one step per count (shift=9 with N=8 takes 9 rotate cycles), giving the modulo-N result.
- start while busy=1, including the DONE cycle, is ignored; there is no queueing. Changes on in_a or shift after acceptance have no effect.
- start held high continuously: a new operation is accepted on the first edge back in IDLE. Back-to-back throughput is therefore shift+3 cycles per operation.
- Reset asserted mid-operation aborts immediately to the reset values. No done is produced for the aborted operation.
- No X propagation: every register has a reset value.

Decomposition:
- Shared ALU package holds the state encodings (IDLE=2'd0, ROTATE=2'd1, DONE=2'd2) and the default widths N=8, S=4.
- A single module is natural. An optional sub-module, rotl1_step (combinational rotate-left-by-one, N-bit), keeps the datapath symmetric with the right rotater. The S-bit down counter stays inline.

Test Plan:
- Reset: assert reset mid-ROTATE (in_a=8'hF0, shift=5, after 2 cycles) -> out=0, cout=0, busy=0, done=0 immediately; no done pulse follows after release.
- Single step: in_a=8'b11110000, shift=1 -> done in the cycle after edge k+2; out=8'b11100001, cout=1.
- Multi step: in_a=8'b01111000, shift=3 -> done after edge k+4; out=8'b11000011, cout=1 (=in_a[5]).
- Zero count: in_a=8'b10100101, shift=0 -> done after edge k+1; out=8'b10100101, cout=0.
- Over-range count: in_a=8'b00000001, shift=9 -> done after edge k+10; out=8'b00000010, cout=0 (=in_a[7]); shift=8 -> out=8'b00000001, cout=1 (=in_a[0]).
- Handshake: start pulsed during ROTATE and during DONE with a different in_a -> ignored, first result unchanged. start held high -> second operation begins on the first edge in IDLE. done is never high for more than 1 cycle. A self-check against the rotl/cout formula is run for all 256 in_a values x 16 shift values.
